// File: rtl/btn_debounce_bank.sv
// btn_debounce_bank: a bank of independent button filters. Each channel has a
// 2-FF synchroniser, a stability counter that must see STABLE_CYCLES
// consecutive disagreeing samples before the debounced level follows, and a
// long-press timer that fires one strobe per press. Every output comes straight
// from a flop.
module btn_debounce_bank #(
  parameter int   CHANNELS      = 4,
  parameter int   STABLE_CYCLES = 16,
  parameter int   LONG_CYCLES   = 1000,
  parameter logic IDLE_LEVEL    = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] long_press
);

  localparam int SW = $clog2(STABLE_CYCLES);
  // Width is never zero, even when long-press detection is disabled.
  localparam int HW = (LONG_CYCLES > 0) ? $clog2(LONG_CYCLES + 1) : 1;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic          sync1_reg;
      logic          sync2_reg;
      logic          out_reg;
      logic          rise_reg;
      logic          fall_reg;
      logic [SW-1:0] scnt_reg;

      // Synchronise the pin, then let the level follow only after a full run
      // of disagreeing samples; any agreeing sample restarts the run.
      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_reg <= IDLE_LEVEL;
          sync2_reg <= IDLE_LEVEL;
          out_reg   <= IDLE_LEVEL;
          rise_reg  <= 1'b0;
          fall_reg  <= 1'b0;
          scnt_reg  <= '0;
        end else begin
          sync1_reg <= btn_in[gi];
          sync2_reg <= sync1_reg;
          rise_reg  <= 1'b0;
          fall_reg  <= 1'b0;
          if (sync2_reg == out_reg) begin
            scnt_reg <= '0;
          end else if (scnt_reg == SW'(STABLE_CYCLES - 1)) begin
            out_reg  <= sync2_reg;
            scnt_reg <= '0;
            // Strobes land in the first cycle of the new level.
            rise_reg <= sync2_reg;
            fall_reg <= ~sync2_reg;
          end else begin
            scnt_reg <= scnt_reg + SW'(1);
          end
        end
      end

      assign btn_out[gi] = out_reg;
      assign rise[gi]    = rise_reg;
      assign fall[gi]    = fall_reg;

      if (LONG_CYCLES > 0) begin : g_long
        logic [HW-1:0] hcnt_reg;
        logic          long_reg;

        // Time the pressed level; saturation at the threshold prevents a
        // second strobe until the channel has been released.
        always_ff @(posedge clk) begin
          if (rst) begin
            hcnt_reg <= '0;
            long_reg <= 1'b0;
          end else begin
            if (out_reg == IDLE_LEVEL) begin
              hcnt_reg <= '0;
            end else if (hcnt_reg != HW'(LONG_CYCLES)) begin
              hcnt_reg <= hcnt_reg + HW'(1);
            end
            long_reg <= (out_reg != IDLE_LEVEL) &&
                        (hcnt_reg == HW'(LONG_CYCLES - 1));
          end
        end

        assign long_press[gi] = long_reg;
      end else begin : g_no_long
        assign long_press[gi] = 1'b0;
      end
    end
  endgenerate

endmodule

// File: doc/btn_debounce_bank.md
# btn_debounce_bank

Parametrised multi-channel successor to the single-channel button filter. Each channel has its own 2-FF synchroniser, its own stability counter and its own long-press timer; channels never interact. The block outputs a debounced level, one-cycle rise/fall strobes and a one-cycle long-press strobe per channel. It sits between raw board pins and control logic such as LED controllers and counters, so no separate synchroniser or edge detector is needed downstream.

## Interface
- `CHANNELS`, 4: number of independent button channels (≥1).
- `STABLE_CYCLES`, 16: consecutive cycles a synchronised input must differ from `btn_out` before `btn_out` follows it (≥2).
- `LONG_CYCLES`, 1000: cycles in the pressed state before `long_press` fires; 0 disables long-press detection.
- `IDLE_LEVEL`, 1'b0: released (idle) electrical level of every channel; pressed = `!IDLE_LEVEL`.
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn_in`  in  CHANNELS  raw asynchronous button inputs.
- `btn_out`  out  CHANNELS  debounced level, registered.
- `rise`  out  CHANNELS  1-cycle strobe when `btn_out[i]` goes 0→1.
- `fall`  out  CHANNELS  1-cycle strobe when `btn_out[i]` goes 1→0.
- `long_press`  out  CHANNELS  1-cycle strobe after `LONG_CYCLES` cycles continuously pressed.

## Operation
- Per channel: `sync1 <= btn_in[i]`, then `sync2 <= sync1`. Only `sync2` is used downstream.
- Stability counter `scnt`, width `$clog2(STABLE_CYCLES)`:
  - If `sync2 == btn_out[i]`, set `scnt <= 0`. Any mismatch gap fully restarts the count.
  - If they differ and `scnt == STABLE_CYCLES-1`, set `btn_out[i] <= sync2` and `scnt <= 0`.
  - If they differ otherwise, set `scnt <= scnt+1`.
- `rise` and `fall` are registered in the same edge that updates `btn_out`, so a strobe is coincident with the first cycle of the new level. They are never both high.
- Hold counter `hcnt`, width `$clog2(LONG_CYCLES+1)`:
  - Cleared while the channel is released (`btn_out == IDLE_LEVEL`).
  - Counts each cycle while pressed, and saturates at `LONG_CYCLES`.
  - On the edge where `hcnt == LONG_CYCLES-1`, set `long_press[i] <= 1` for exactly one cycle.
  - No repeat until the channel is released and pressed again.
  - A release before the threshold means no strobe.
- `LONG_CYCLES == 0`: `long_press` is tied to 0 and `hcnt` is unused.
- Reset values:
  - `sync1`, `sync2` and `btn_out` all become `IDLE_LEVEL`.
  - `scnt`, `hcnt`, `rise`, `fall` and `long_press` all become 0.
- Reset asserted mid-count discards all progress. No strobe is emitted because of reset, and the first edge after reset release is treated as a normal cycle.

## Timing
- Latency: `btn_in` changes between edges 0 and 1 and then stays stable. `sync2` updates at edge 2, and `btn_out` plus the strobe update at edge `2+STABLE_CYCLES`. With the default, that is 18 cycles.
- Rejection: a pulse on `sync2` lasting ≤ `STABLE_CYCLES-1` cycles never changes `btn_out`.
- Long press: the `long_press` strobe is high exactly `LONG_CYCLES` cycles after the cycle in which `rise` (or `fall`, when `IDLE_LEVEL=1`) was high.
- Simultaneous events on different channels are handled independently in the same cycle.
- All outputs are driven directly from flops. There is no combinational path from `btn_in` to any output.

## Test plan
All scenarios use `CHANNELS=4`, `STABLE_CYCLES=4`, `LONG_CYCLES=10`, `IDLE_LEVEL=0`, with a clean reset for 3 cycles first.
- Reset: during and after reset, `btn_out=4'b0000` and `rise`/`fall`/`long_press` are 0. Drive `btn_in=4'b1111` during reset and hold it 2 cycles past release → no output change within 5 cycles of release.
- Clean step: `btn_in[0]` goes 0→1 before edge 1 and is held. `btn_out[0]=1` and `rise[0]=1` after edge 6, with `rise[0]=0` after edge 7. The 1→0 step mirrors this with `fall[0]`.
- Bounce: on `btn_in[1]`, toggle 1,0,1,1,0 (1 cycle each), then hold 1. `btn_out[1]` rises exactly 6 cycles after the final 0→1, and exactly one `rise[1]` strobe occurs.
- Glitch: a 3-cycle high pulse on `btn_in[2]` → `btn_out[2]` stays 0 and no strobes occur.
- Long press: hold `btn_in[3]=1`. `long_press[3]` is high for 1 cycle, 10 cycles after `rise[3]`, with no repeat over a further 50 cycles. Releasing and re-pressing for 8 cycles gives no strobe.
- Independence and reset mid-count:
  - Step channels 0 and 2 in the same cycle → both `rise` strobes are coincident and channels 1 and 3 stay quiet.
  - Assert `rst` 2 cycles into a stable count → outputs return to reset values and no strobe appears.
